// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, legal parameter ranges, parity helper.
`timescale 1ns/1ps

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_e;

    localparam int unsigned DATA_BITS_MIN = 5;
    localparam int unsigned DATA_BITS_MAX = 9;
    localparam int unsigned OVS_MIN       = 8;
    localparam int unsigned OVS_MAX       = 32;
    localparam int unsigned STOP_BITS_MIN = 1;
    localparam int unsigned STOP_BITS_MAX = 2;

    // Expected parity bit for a zero-extended data word; odd = 1 selects odd parity.
    function automatic logic parity_bit(input logic [DATA_BITS_MAX-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rxd front end: 2-FF synchroniser, oversampling tick counter, 3-sample majority vote,
// mid-bit decision strobe and falling-edge detect on the synchronised line.
`timescale 1ns/1ps

module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned OVS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    input  logic rxd,
    input  logic clear,
    output logic fall_c,
    output logic mid_bit_c,
    output logic bit_c
);

    localparam int unsigned CNT_W = $clog2(OVS);
    localparam int unsigned MID   = OVS / 2;

    if (OVS < OVS_MIN || OVS > OVS_MAX || (OVS % 2) != 0) begin : g_ovs_check
        $error("uart_rx_sampler: OVS out of range or odd");
    end

    logic             sync_a;
    logic             sync_b;
    logic             sync_prev;
    logic [CNT_W-1:0] tick_cnt;
    logic             samp_0;
    logic             samp_1;

    // Synchroniser plus one delayed copy for edge detection; idle-high after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a    <= 1'b1;
            sync_b    <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_a    <= rxd;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
        end
    end

    // Tick counter restarts on a start edge so the mid-bit samples align to that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (clear) begin
            tick_cnt <= '0;
        end else if (baud_tick) begin
            tick_cnt <= (tick_cnt == CNT_W'(OVS - 1)) ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    // First two of the three vote samples; the third is the live synchronised value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_0 <= 1'b0;
            samp_1 <= 1'b0;
        end else if (baud_tick) begin
            if (tick_cnt == CNT_W'(MID - 1)) samp_0 <= sync_b;
            if (tick_cnt == CNT_W'(MID))     samp_1 <= sync_b;
        end
    end

    assign fall_c    = sync_prev & ~sync_b;
    assign mid_bit_c = baud_tick && (tick_cnt == CNT_W'(MID + 1));
    assign bit_c     = (samp_0 & samp_1) | (samp_0 & sync_b) | (samp_1 & sync_b);

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver with valid/ready output, overrun and framing/parity flags.
// Optional parity checking is compiled in with UART_RX_PARITY_EN.
`timescale 1ns/1ps

module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVS        = 16,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_en,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned BCNT_W = $clog2(DATA_BITS_MAX + 1);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX || PARITY_ODD > 1) begin : g_param_check
        $error("uart_rx_oversampled: illegal parameter value");
    end

    rx_state_e             state;
    rx_state_e             nxt;
    logic                  fall_c;
    logic                  mid_bit_c;
    logic                  bit_c;
    logic                  clear_c;
    logic                  shift_c;
    logic                  stop_c;
    logic                  load_c;
    logic [BCNT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  fe_acc;
    logic                  pe_acc;
`ifdef UART_RX_PARITY_EN
    logic                  par_c;
`endif

    uart_rx_sampler #(.OVS(OVS)) u_sampler (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rxd       (rxd),
        .clear     (clear_c),
        .fall_c    (fall_c),
        .mid_bit_c (mid_bit_c),
        .bit_c     (bit_c)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    // Next-state logic; rx_en low overrides everything and returns to IDLE.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (fall_c) nxt = ST_START;
            ST_START: if (mid_bit_c) nxt = bit_c ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (mid_bit_c && bit_cnt == BCNT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    nxt = ST_PARITY;
`else
                    nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (mid_bit_c) nxt = ST_STOP;
`else
            ST_PARITY: nxt = ST_IDLE;
`endif
            ST_STOP:  if (mid_bit_c && bit_cnt == BCNT_W'(STOP_BITS - 1)) nxt = ST_DONE;
            ST_DONE:  nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
        if (!rx_en) nxt = ST_IDLE;
    end

    // FSM decode of datapath strobes.
    always_comb begin
        clear_c = 1'b0;
        shift_c = 1'b0;
        stop_c  = 1'b0;
        load_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_c   = 1'b0;
        if (state == ST_PARITY && mid_bit_c) par_c = 1'b1;
`endif
        if (state == ST_IDLE && fall_c && rx_en) clear_c = 1'b1;
        if (state == ST_DATA && mid_bit_c)       shift_c = 1'b1;
        if (state == ST_STOP && mid_bit_c)       stop_c  = 1'b1;
        if (state == ST_DONE)                    load_c  = 1'b1;
    end

    // Bit counter restarts on every state change; counts voted bits in DATA and STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (state != nxt) begin
            bit_cnt <= '0;
        end else if ((state == ST_DATA || state == ST_STOP) && mid_bit_c) begin
            bit_cnt <= bit_cnt + BCNT_W'(1);
        end
    end

    // LSB-first shifter and framing-error accumulator for the frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            fe_acc    <= 1'b0;
        end else begin
            if (shift_c) shift_reg <= {bit_c, shift_reg[DATA_BITS-1:1]};
            if (clear_c)                 fe_acc <= 1'b0;
            else if (stop_c && !bit_c)   fe_acc <= 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity check against the fully shifted data word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_acc <= 1'b0;
        end else if (clear_c) begin
            pe_acc <= 1'b0;
        end else if (par_c) begin
            pe_acc <= bit_c ^ parity_bit(DATA_BITS_MAX'(shift_reg), 1'(PARITY_ODD));
        end
    end
`else
    assign pe_acc = 1'b0;
`endif

    // Busy mirrors the registered state leaving IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= 1'b0;
        else     busy <= (nxt != ST_IDLE);
    end

    // Output holding register: load on DONE unless an unaccepted word blocks it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load_c && rx_valid && !rx_ready) begin
                overrun <= 1'b1;
            end else if (load_c) begin
                rx_valid   <= 1'b1;
                rx_data    <= shift_reg;
                frame_err  <= fe_acc;
                parity_err <= pe_acc;
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                rx_data    <= '0;
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: directed corner cases plus randomized
// frames scored against a frame-level reference model.
`timescale 1ns/1ps

module tb_uart_rx_oversampled;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVS        = 16;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned PARITY_ODD = 0;
    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned BIT_CLKS   = OVS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned PAR_BITS   = 1;
`else
    localparam int unsigned PAR_BITS   = 0;
`endif
    localparam int unsigned FRAME_CLKS = (1 + DATA_BITS + PAR_BITS + STOP_BITS) * BIT_CLKS;

    logic                 clk;
    logic                 rst;
    logic                 baud_tick;
    logic                 rx_en;
    logic                 rxd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    int n_checks;
    int n_errors;
    int ovr_cnt;
    int vrise_cnt;
    int tick_div;
    logic valid_prev;
    logic sb_on;
    logic [9:0] exp_q[$];

    uart_rx_oversampled #(
        .DATA_BITS (DATA_BITS),
        .OVS       (OVS),
        .STOP_BITS (STOP_BITS),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx_en     (rx_en),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-clock baud_tick every TICK_DIV clocks.
    initial begin
        tick_div  = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_div  = (tick_div + 1) % TICK_DIV;
            baud_tick = (tick_div == 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: parity bit a correct transmitter would send.
    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ PARITY_ODD[0];
    endfunction

    // Reference: receiver verdict for one frame as {parity_err, frame_err, data}.
    function automatic logic [9:0] model(input logic [7:0] d, input logic stop_val, input logic par_val);
        logic pe;
        pe = (PAR_BITS != 0) ? (par_val != good_par(d)) : 1'b0;
        return {pe, ~stop_val, d};
    endfunction

    // Event counters for overrun pulses and rx_valid rising edges.
    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
        if (rx_valid && !valid_prev) vrise_cnt++;
        valid_prev = rx_valid;
    end

    // Scoreboard: every accepted word must match the next modelled frame.
    always @(negedge clk) begin
        logic [9:0] e;
        #2;
        if (sb_on && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(rx_data), 32'(e[7:0]));
                check("sb_frame_err", 32'(frame_err), 32'(e[8]));
                check("sb_parity_err", 32'(parity_err), 32'(e[9]));
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic par_val, input int spike_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < DATA_BITS; i++) begin
            rxd = d[i];
            if (i == spike_bit) begin
                repeat (BIT_CLKS / 2 - 2) @(negedge clk);
                rxd = 1'b1;
                repeat (TICK_DIV) @(negedge clk);
                rxd = d[i];
                repeat (BIT_CLKS / 2 - 2) @(negedge clk);
            end else begin
                repeat (BIT_CLKS) @(negedge clk);
            end
        end
`ifdef UART_RX_PARITY_EN
        rxd = par_val;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        for (int s = 0; s < STOP_BITS; s++) begin
            rxd = stop_val;
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic wait_valid(output bit seen, output logic [7:0] dat, output logic fe,
                              output logic pe, output logic vnext);
        seen = 1'b0; dat = '0; fe = 1'b0; pe = 1'b0; vnext = 1'b0;
        for (int k = 0; k < int'(FRAME_CLKS) + 200; k++) begin
            @(negedge clk);
            if (rx_valid) begin
                seen = 1'b1;
                dat  = rx_data;
                fe   = frame_err;
                pe   = parity_err;
                @(negedge clk);
                vnext = rx_valid;
                break;
            end
        end
    endtask

    task automatic recv(input logic [7:0] d, input logic stop_val, input logic par_val, input int spike,
                        output bit seen, output logic [7:0] dat, output logic fe,
                        output logic pe, output logic vnext);
        fork
            send_frame(d, stop_val, par_val, spike);
            wait_valid(seen, dat, fe, pe, vnext);
        join
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         seen;
        logic [7:0] dat;
        logic       fe;
        logic       pe;
        logic       vn;
        int         o0;
        int         v0;
        logic [7:0] rd;
        logic       rs;
        logic       rp;

        n_checks = 0; n_errors = 0; ovr_cnt = 0; vrise_cnt = 0;
        valid_prev = 1'b0; sb_on = 1'b0;
        rst = 1'b1; rxd = 1'b1; rx_en = 1'b1; rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Clean 0x55 with consumer always ready: one-clock valid.
        rx_ready = 1'b1;
        recv(8'h55, 1'b1, good_par(8'h55), -1, seen, dat, fe, pe, vn);
        check("x55_seen", 32'(seen), 32'd1);
        check("x55_data", 32'(dat), 32'h55);
        check("x55_frame_err", 32'(fe), 32'd0);
        check("x55_parity_err", 32'(pe), 32'd0);
        check("x55_valid_one_clk", 32'(vn), 32'd0);
        repeat (20) @(negedge clk);

        // Overrun: 0xA3 held, then 0x3C arrives and is dropped.
        rx_ready = 1'b0;
        recv(8'hA3, 1'b1, good_par(8'hA3), -1, seen, dat, fe, pe, vn);
        check("a3_seen", 32'(seen), 32'd1);
        check("a3_data", 32'(dat), 32'hA3);
        o0 = ovr_cnt;
        send_frame(8'h3C, 1'b1, good_par(8'h3C), -1);
        repeat (40) @(negedge clk);
        check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        check("ovr_data_kept", 32'(rx_data), 32'hA3);
        check("ovr_valid_held", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        check("ovr_accept_valid", 32'(rx_valid), 32'd0);
        check("ovr_accept_data", 32'(rx_data), 32'd0);
        repeat (20) @(negedge clk);

        // Short low glitch on idle line: false start.
        v0 = vrise_cnt;
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_up", 32'(busy), 32'd1);
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_busy_down", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(vrise_cnt - v0), 32'd0);

        // Stop bit forced low.
        recv(8'hF0, 1'b0, good_par(8'hF0), -1, seen, dat, fe, pe, vn);
        check("f0_seen", 32'(seen), 32'd1);
        check("f0_data", 32'(dat), 32'hF0);
        check("f0_frame_err", 32'(fe), 32'd1);
        repeat (20) @(negedge clk);

        // One-tick spike inside data bit 2 of 0x00 is outvoted.
        recv(8'h00, 1'b1, good_par(8'h00), 2, seen, dat, fe, pe, vn);
        check("spike_seen", 32'(seen), 32'd1);
        check("spike_data", 32'(dat), 32'h00);
        check("spike_frame_err", 32'(fe), 32'd0);
        repeat (20) @(negedge clk);

        // rx_en dropped mid-frame aborts without output.
        v0 = vrise_cnt;
        fork
            send_frame(8'h99, 1'b1, good_par(8'h99), -1);
            begin
                repeat (BIT_CLKS * 4) @(negedge clk);
                rx_en = 1'b0;
                @(negedge clk);
                check("abort_busy", 32'(busy), 32'd0);
            end
        join
        repeat (20) @(negedge clk);
        rx_en = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_valid", 32'(vrise_cnt - v0), 32'd0);

        // Break: line low for longer than a frame.
        fork
            begin
                rxd = 1'b0;
                repeat (FRAME_CLKS + 3 * BIT_CLKS) @(negedge clk);
            end
            wait_valid(seen, dat, fe, pe, vn);
        join
        check("break_seen", 32'(seen), 32'd1);
        check("break_data", 32'(dat), 32'd0);
        check("break_frame_err", 32'(fe), 32'd1);
        check("break_idle_wait", 32'(busy), 32'd0);
        rxd = 1'b1;
        repeat (50) @(negedge clk);

        // Reset mid-frame drops a pending word and the frame in flight.
        rx_ready = 1'b0;
        recv(8'h11, 1'b1, good_par(8'h11), -1, seen, dat, fe, pe, vn);
        check("pend_seen", 32'(seen), 32'd1);
        fork
            send_frame(8'h81, 1'b1, good_par(8'h81), -1);
            begin
                repeat (BIT_CLKS * 5) @(negedge clk);
                rst = 1'b1;
                #1;
                check("rst_rx_valid", 32'(rx_valid), 32'd0);
                check("rst_rx_data", 32'(rx_data), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        rx_ready = 1'b1;
        repeat (20) @(negedge clk);
        recv(8'h42, 1'b1, good_par(8'h42), -1, seen, dat, fe, pe, vn);
        check("x42_seen", 32'(seen), 32'd1);
        check("x42_data", 32'(dat), 32'h42);
        check("x42_frame_err", 32'(fe), 32'd0);
        check("x42_parity_err", 32'(pe), 32'd0);
        repeat (20) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        recv(8'h07, 1'b1, 1'b0, -1, seen, dat, fe, pe, vn);
        check("par07_bad_parity_err", 32'(pe), 32'd1);
        repeat (20) @(negedge clk);
        recv(8'h07, 1'b1, 1'b1, -1, seen, dat, fe, pe, vn);
        check("par07_good_parity_err", 32'(pe), 32'd0);
        repeat (20) @(negedge clk);
`endif

        // Randomized frames with a randomly stalling consumer.
        o0 = ovr_cnt;
        sb_on = 1'b1;
        for (int n = 0; n < 24; n++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rp = good_par(rd) ^ ($urandom_range(0, 3) == 0);
            exp_q.push_back(model(rd, rs, rp));
            fork
                send_frame(rd, rs, rp, -1);
                begin
                    repeat (FRAME_CLKS) begin
                        @(negedge clk);
                        rx_ready = 1'($urandom_range(0, 1));
                    end
                end
            join
            rx_ready = 1'b1;
            repeat ($urandom_range(5, 60)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        sb_on = 1'b0;
        check("sb_all_received", 32'(exp_q.size()), 32'd0);
        check("random_no_overrun", 32'(ovr_cnt - o0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
